// File: rtl/serdes_pkg.sv
// Shared types, line levels and frame arithmetic for the serial link
// (transmitter today, receiver later).
package serdes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Clock cycles from the first start-bit cycle to the last stop-bit cycle.
  function automatic int frame_cycles(input int logic_size, input int clks_per_bit,
                                      input int parity_en);
    return (logic_size + parity_en + 2) * clks_per_bit;
  endfunction

endpackage

// File: rtl/serdes_bit_timer.sv
// Bit-period timer: ticks once every CLKS_PER_BIT cycles; i_clear realigns
// the period so the first tick lands on the last cycle of a new bit.
module serdes_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_reg;

  assign o_tick = (count_reg == LAST_COUNT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_reg <= '0;
    end else if (i_clear || o_tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/axis_serdes_tx.sv
// Serial transmitter draining an async-FIFO read port: start bit, LSB-first
// data, optional even parity, stop bit; one idle-high WAIT cycle between frames.
module axis_serdes_tx
  import serdes_pkg::*;
#(
  parameter int LOGIC_SIZE   = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_rempty,
  output logic                  o_rr,
  input  logic [LOGIC_SIZE-1:0] i_rdata,
  output logic                  o_serial,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  localparam int BW = (LOGIC_SIZE > 1) ? $clog2(LOGIC_SIZE) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(LOGIC_SIZE - 1);

  tx_state_t             state_reg, state_next;
  logic [LOGIC_SIZE-1:0] shift_reg, shift_next;
  logic [BW-1:0]         bit_cnt_reg;
  logic                  parity_reg;
  logic                  tick;
  logic                  can_read;
  logic                  timer_clear;

  // Reset is folded in so no read request escapes while the block is held.
  assign can_read    = i_rst_n & i_en & ~i_rempty;
  assign timer_clear = (state_reg == WAIT);

  serdes_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clear(timer_clear),
    .o_tick (tick)
  );

  genvar gi;
  generate
    for (gi = 0; gi < LOGIC_SIZE; gi++) begin : g_shift
      if (gi == LOGIC_SIZE - 1) begin : g_msb
        assign shift_next[gi] = 1'b0;
      end else begin : g_bit
        assign shift_next[gi] = shift_reg[gi+1];
      end
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    o_rr         = 1'b0;
    o_serial     = IDLE_LEVEL;
    o_busy       = 1'b1;
    o_frame_done = 1'b0;
    case (state_reg)
      IDLE: begin
        o_busy = 1'b0;
        o_rr   = can_read;
        if (can_read) state_next = WAIT;
      end
      WAIT: begin
        state_next = START;
      end
      START: begin
        o_serial = START_LEVEL;
        if (tick) state_next = DATA;
      end
      DATA: begin
        o_serial = shift_reg[0];
        if (tick && (bit_cnt_reg == LAST_BIT)) begin
          state_next = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        o_serial = parity_reg;
        if (tick) state_next = STOP;
      end
      STOP: begin
        o_serial = STOP_LEVEL;
        if (tick) begin
          o_frame_done = 1'b1;
          o_rr         = can_read;
          state_next   = can_read ? WAIT : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Parity is taken from the whole word at capture, before shifting destroys it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      parity_reg  <= 1'b0;
    end else if (state_reg == WAIT) begin
      shift_reg   <= i_rdata;
      bit_cnt_reg <= '0;
      parity_reg  <= ^i_rdata;
    end else if ((state_reg == DATA) && tick) begin
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_reg + BW'(1);
    end
  end

endmodule

// File: tb/tb_axis_serdes_tx.sv
// Self-checking bench: three transmitter configurations against a frame-queue
// model, plus literal cycle expectations for the documented waveforms.
module tb_axis_serdes_tx;
  import serdes_pkg::*;

  localparam int NI = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [NI-1:0] rempty;
  logic [7:0]    rdata [NI];
  logic [NI-1:0] d_rr, d_serial, d_busy, d_done;

  logic [7:0] fifo [NI][$];
  logic [2:0] expq [NI][$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit rec_on = 1'b0;
  int rec_k = 0;
  int rec_t0 = 0;
  int rec_rrcnt = 0;
  logic rec_serial [200];
  logic rec_rr     [200];
  logic rec_busy   [200];
  logic rec_done   [200];

  always #5 clk = ~clk;

  axis_serdes_tx #(.LOGIC_SIZE(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_rempty(rempty[0]), .o_rr(d_rr[0]),
    .i_rdata(rdata[0]), .o_serial(d_serial[0]), .o_busy(d_busy[0]), .o_frame_done(d_done[0]));

  axis_serdes_tx #(.LOGIC_SIZE(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_rempty(rempty[1]), .o_rr(d_rr[1]),
    .i_rdata(rdata[1]), .o_serial(d_serial[1]), .o_busy(d_busy[1]), .o_frame_done(d_done[1]));

  axis_serdes_tx #(.LOGIC_SIZE(8), .CLKS_PER_BIT(1), .PARITY_EN(1)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_rempty(rempty[2]), .o_rr(d_rr[2]),
    .i_rdata(rdata[2]), .o_serial(d_serial[2]), .o_busy(d_busy[2]), .o_frame_done(d_done[2]));

  function automatic int cpb_of(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic int pen_of(input int k);
    return (k == 0) ? 0 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected line activity after a read, one {serial,busy,done} entry per cycle.
  task automatic launch(input int k, input logic [7:0] w);
    int   cpb, pen, nb;
    logic b;
    cpb = cpb_of(k);
    pen = pen_of(k);
    nb  = 8 + pen + 2;
    expq[k].push_back(3'b110);
    for (int j = 0; j < nb; j++) begin
      if (j == 0) b = 1'b0;
      else if (j <= 8) b = w[j-1];
      else if (pen != 0 && j == 9) b = ^w;
      else b = 1'b1;
      for (int c = 0; c < cpb; c++) begin
        expq[k].push_back({b, 1'b1, (j == nb - 1) && (c == cpb - 1)});
      end
    end
  endtask

  task automatic push(input int k, input logic [7:0] w);
    fifo[k].push_back(w);
    rempty[k] = 1'b0;
  endtask

  // One clock: compare at the falling edge, then drive FIFO inputs just after the rise.
  task automatic tick();
    logic [NI-1:0] er;
    logic [2:0]    e;
    int            idx;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      e = 3'b100;
      if (!rst_n) expq[k].delete();
      else if (expq[k].size() > 0) e = expq[k].pop_front();
      er[k] = rst_n && en && (fifo[k].size() > 0) && (expq[k].size() == 0);
      chk($sformatf("rr%0d", k), d_rr[k], er[k]);
      chk($sformatf("serial%0d", k), d_serial[k], e[2]);
      chk($sformatf("busy%0d", k), d_busy[k], e[1]);
      chk($sformatf("done%0d", k), d_done[k], e[0]);
      if (er[k]) launch(k, fifo[k][0]);
    end
    if (rec_on) begin
      idx = cyc - rec_t0;
      if (idx >= 0 && idx < 200) begin
        rec_serial[idx] = d_serial[rec_k];
        rec_rr[idx]     = d_rr[rec_k];
        rec_busy[idx]   = d_busy[rec_k];
        rec_done[idx]   = d_done[rec_k];
      end
      if (d_rr[rec_k]) rec_rrcnt++;
    end
    cyc++;
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      if (er[k]) rdata[k] = fifo[k].pop_front();
      else rdata[k] = 8'($urandom);
      rempty[k] = (fifo[k].size() == 0);
    end
  endtask

  task automatic start_rec(input int k);
    rec_on    = 1'b1;
    rec_k     = k;
    rec_t0    = cyc;
    rec_rrcnt = 0;
  endtask

  task automatic drain();
    int  budget;
    bit  pending;
    budget  = 3000;
    pending = 1'b1;
    while (pending && budget > 0) begin
      pending = 1'b0;
      for (int k = 0; k < NI; k++) begin
        if (expq[k].size() > 0 || fifo[k].size() > 0) pending = 1'b1;
      end
      if (pending) begin
        tick();
        budget--;
      end
    end
    chk("drain_within_budget", 32'(budget > 0), 32'd1);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:7] seq;
    rst_n  = 1'b0;
    en     = 1'b1;
    rempty = '1;
    for (int k = 0; k < NI; k++) rdata[k] = 8'($urandom);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Single word 0xA5 at defaults
    start_rec(0);
    push(0, 8'hA5);
    repeat (46) tick();
    rec_on = 1'b0;
    chk("a5_rr_c0", rec_rr[0], 1);
    chk("a5_busy_c0", rec_busy[0], 0);
    chk("a5_wait_high_c1", rec_serial[1], 1);
    chk("a5_busy_c1", rec_busy[1], 1);
    for (int i = 2; i <= 5; i++) chk("a5_start_low", rec_serial[i], 0);
    seq = 8'b1010_0101;
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < 4; c++) chk("a5_data_bit", rec_serial[6 + 4 * i + c], 32'(seq[i]));
    for (int i = 38; i <= 41; i++) chk("a5_stop_high", rec_serial[i], 1);
    chk("a5_done_c40", rec_done[40], 0);
    chk("a5_done_at_frame_end", rec_done[1 + frame_cycles(8, 4, 0)], 1);
    chk("a5_busy_c41", rec_busy[41], 1);
    chk("a5_busy_c42", rec_busy[42], 0);
    chk("a5_single_read", rec_rrcnt, 1);
    drain();

    // Empty FIFO with enable high
    start_rec(0);
    repeat (100) tick();
    rec_on = 1'b0;
    chk("empty_no_reads", rec_rrcnt, 0);
    chk("empty_line_high", rec_serial[57], 1);

    // Back-to-back 0x01 then 0xFF
    start_rec(0);
    push(0, 8'h01);
    push(0, 8'hFF);
    repeat (82) tick();
    rec_on = 1'b0;
    chk("b2b_first_bit0", rec_serial[6], 1);
    chk("b2b_first_bit1", rec_serial[10], 0);
    chk("b2b_rr_c41", rec_rr[41], 1);
    chk("b2b_wait_high_c42", rec_serial[42], 1);
    chk("b2b_wait_busy_c42", rec_busy[42], 1);
    for (int i = 43; i <= 46; i++) chk("b2b_start_low", rec_serial[i], 0);
    for (int i = 47; i <= 78; i++) chk("b2b_data_ones", rec_serial[i], 1);
    chk("b2b_two_reads", rec_rrcnt, 2);
    drain();

    // Even parity, 0x07 then 0x03
    start_rec(1);
    push(1, 8'h07);
    repeat (47) tick();
    rec_on = 1'b0;
    for (int i = 38; i <= 41; i++) chk("par07_parity_one", rec_serial[i], 1);
    for (int i = 42; i <= 45; i++) chk("par07_stop_high", rec_serial[i], 1);
    chk("par07_done_c41", rec_done[41], 0);
    chk("par07_done_c45", rec_done[45], 1);
    drain();
    start_rec(1);
    push(1, 8'h03);
    repeat (47) tick();
    rec_on = 1'b0;
    chk("par03_parity_zero_c38", rec_serial[38], 0);
    chk("par03_parity_zero_c41", rec_serial[41], 0);
    chk("par03_stop_c42", rec_serial[42], 1);
    drain();

    // Enable drops during data bit 2 with words still queued
    start_rec(0);
    push(0, 8'h96);
    push(0, 8'h33);
    push(0, 8'hC1);
    repeat (15) tick();
    en = 1'b0;
    repeat (60) tick();
    rec_on = 1'b0;
    chk("endrop_done_c41", rec_done[41], 1);
    chk("endrop_one_read", rec_rrcnt, 1);
    chk("endrop_idle_busy", rec_busy[50], 0);
    chk("endrop_idle_high", rec_serial[70], 1);
    fifo[0].delete();
    rempty[0] = 1'b1;
    en = 1'b1;
    drain();

    // Asynchronous reset during data bit 3
    push(0, 8'h3C);
    push(0, 8'h5A);
    repeat (19) tick();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_async_serial", d_serial[k], 1);
      chk("rst_async_busy", d_busy[k], 0);
      chk("rst_async_rr", d_rr[k], 0);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    start_rec(0);
    repeat (50) tick();
    rec_on = 1'b0;
    chk("rst_release_rr", rec_rr[0], 1);
    chk("rst_release_start", rec_serial[2], 0);
    drain();

    // Randomized traffic across all three configurations
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NI; k++) begin
        if ($urandom_range(0, 9) == 0 && fifo[k].size() < 4) push(k, 8'($urandom));
      end
      if ($urandom_range(0, 199) == 0) en = ~en;
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
      end
      tick();
    end
    en = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
